tmcu_uart_rx_fifo: RTL

Robust UART receiver for the t-mcu peripheral bus side. It takes the external serial line, samples it at 16x the baud rate with majority voting, and checks framing. Received bytes are buffered in a FIFO with a show-ahead read interface. Sticky overrun, framing-error and break flags are exposed to the status register block.

---
 rtl/tmcu_uart_rx_fifo.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/tmcu_uart_rx_fifo.sv
`timescale 1ns/1ps
// tmcu_uart_rx_fifo: 16x oversampled UART receiver with majority vote,
// framing/break detection and a show-ahead receive FIFO.
module tmcu_uart_rx_fifo #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx,
  input  logic                              rd_en,
  output logic [7:0]                        rd_data,
  output logic                              rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  input  logic                              clear_err,
  output logic                              overrun,
  output logic                              frame_err,
  output logic                              break_det
);

  localparam int OS_DIV =
    (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
  localparam int DW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, IDLE_WAIT
  } state_e;

  state_e         state_q, state_d;
  logic           rx_m_q, rx_s_q, prev_q, arm_q;
  logic [1:0]     vld_q;
  logic [DW-1:0]  div_q, div_d;
  logic [3:0]     s_q, s_d;
  logic [2:0]     bit_q, bit_d;
  logic [1:0]     v_q, v_d;
  logic [7:0]     sh_q, sh_d;
  logic           push_q, push_d;
  logic           fe_set, brk_set;
  logic           os_tick, maj;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           full, empty, pop, push_ok, ovr_set;
  logic           ovr_q, fe_q, brk_q;

  // arm_q keeps a line that is already low out of reset from
  // looking like a start edge: the real line must be seen high first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      prev_q <= 1'b1;
      vld_q  <= 2'b00;
      arm_q  <= 1'b0;
    end else begin
      rx_m_q <= rx;
      rx_s_q <= rx_m_q;
      prev_q <= rx_s_q;
      vld_q  <= {vld_q[0], 1'b1};
      if (vld_q[1] && rx_s_q) arm_q <= 1'b1;
    end
  end

  assign os_tick = (div_q == DW'(OS_DIV - 1));
  assign maj = (v_q[0] & v_q[1]) | (v_q[0] & rx_s_q) |
               (v_q[1] & rx_s_q);

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    s_d     = s_q;
    bit_d   = bit_q;
    v_d     = v_q;
    sh_d    = sh_q;
    push_d  = 1'b0;
    fe_set  = 1'b0;
    brk_set = 1'b0;
    if (state_q != IDLE) begin
      div_d = os_tick ? '0 : div_q + DW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (arm_q && prev_q && !rx_s_q) begin
          state_d = START;
          s_d     = 4'd0;
        end
      end
      START, DATA, STOP: begin
        if (os_tick) begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd7) v_d[0] = rx_s_q;
          if (s_q == 4'd8) v_d[1] = rx_s_q;
          if (s_q == 4'd9) begin
            if (state_q == START && maj) begin
              state_d = IDLE;
            end
            if (state_q == DATA) begin
              sh_d = {maj, sh_q[7:1]};
            end
            if (state_q == STOP) begin
              if (maj) begin
                push_d  = 1'b1;
                state_d = IDLE;
              end else begin
                fe_set  = 1'b1;
                brk_set = (sh_q == 8'h00);
                state_d = IDLE_WAIT;
              end
            end
          end
          if (s_q == 4'd15) begin
            if (state_q == START) begin
              state_d = DATA;
              bit_d   = 3'd0;
            end else if (state_q == DATA) begin
              if (bit_q == 3'd7) state_d = STOP;
              else bit_d = bit_q + 3'd1;
            end
          end
        end
      end
      IDLE_WAIT: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      s_q     <= 4'd0;
      bit_q   <= 3'd0;
      v_q     <= 2'b11;
      sh_q    <= 8'h00;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      v_q     <= v_d;
      sh_q    <= sh_d;
      push_q  <= push_d;
    end
  end

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop     = rd_en & ~empty;
  assign push_ok = push_q & (~full | pop);
  assign ovr_set = push_q & full & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop) cnt_d = cnt_q + CW'(1);
    if (pop && !push_ok) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_q] <= sh_q;
  end

  // Sticky flags: a set in the same cycle as clear_err wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      ovr_q <= ovr_set | (ovr_q & ~clear_err);
      fe_q  <= fe_set | (fe_q & ~clear_err);
      brk_q <= brk_set | (brk_q & ~clear_err);
    end
  end

  assign rd_data    = mem_q[rd_q];
  assign rd_valid   = ~empty;
  assign fifo_count = cnt_q;
  assign overrun    = ovr_q;
  assign frame_err  = fe_q;
  assign break_det  = brk_q;

endmodule
